uart_lite_axil_master: RTL and testbench

AXI4-Lite master engine that drives the m01 port of the UART bridge design toward a UART-Lite peripheral mapped at UART_BASE_ADDR. It polls the peripheral status register and moves bytes between the peripheral's RX/TX FIFOs and two byte-wide valid/ready streams on the bridge side. It sits directly downstream of the bridge's byte-stream logic and owns every m01 transaction.

---
 rtl/uart_lite_axil_master.sv | 209 ++++++++++++++++++++
 tb/tb_uart_lite_axil_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_lite_axil_master.sv
// uart_lite_axil_master: AXI4-Lite master that polls a UART-Lite status register
// and moves bytes between its RX/TX FIFOs and two byte-wide valid/ready streams.
module uart_lite_axil_master #(
  parameter int          C_M01_AXI_DATA_WIDTH = 32,
  parameter int          C_M01_AXI_ADDR_WIDTH = 28,
  parameter logic [31:0] UART_BASE_ADDR       = 32'h1100000,
  parameter int          POLL_GAP             = 16
) (
  input  logic                                aclk,
  input  logic                                aresetn,
  input  logic [7:0]                          tx_data_i,
  input  logic                                tx_v_i,
  output logic                                tx_ready_o,
  output logic [7:0]                          rx_data_o,
  output logic                                rx_v_o,
  input  logic                                rx_ready_i,
  output logic                                err_o,
  output logic [C_M01_AXI_ADDR_WIDTH-1:0]     m01_axi_awaddr,
  output logic [2:0]                          m01_axi_awprot,
  output logic                                m01_axi_awvalid,
  input  logic                                m01_axi_awready,
  output logic [C_M01_AXI_DATA_WIDTH-1:0]     m01_axi_wdata,
  output logic [C_M01_AXI_DATA_WIDTH/8-1:0]   m01_axi_wstrb,
  output logic                                m01_axi_wvalid,
  input  logic                                m01_axi_wready,
  input  logic [1:0]                          m01_axi_bresp,
  input  logic                                m01_axi_bvalid,
  output logic                                m01_axi_bready,
  output logic [C_M01_AXI_ADDR_WIDTH-1:0]     m01_axi_araddr,
  output logic [2:0]                          m01_axi_arprot,
  output logic                                m01_axi_arvalid,
  input  logic                                m01_axi_arready,
  input  logic [C_M01_AXI_DATA_WIDTH-1:0]     m01_axi_rdata,
  input  logic [1:0]                          m01_axi_rresp,
  input  logic                                m01_axi_rvalid,
  output logic                                m01_axi_rready
);
  localparam int DW = C_M01_AXI_DATA_WIDTH;
  localparam int AW = C_M01_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [AW-1:0] A_RX   = UART_BASE_ADDR[AW-1:0];
  localparam logic [AW-1:0] A_TX   = A_RX + AW'(4);
  localparam logic [AW-1:0] A_STAT = A_RX + AW'(8);
  localparam logic [AW-1:0] A_CTRL = A_RX + AW'(12);
  localparam logic [15:0]   GAP_LD = (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);

  typedef enum logic [3:0] {INIT_W, INIT_B, POLL_AR, POLL_R, RX_AR, RX_R, TX_W, TX_B, GAP} state_t;

  state_t          state_q, state_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [AW-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic            tx_ready_q, tx_ready_d, rx_v_q, rx_v_d;
  logic [7:0]      tx_byte_q, tx_byte_d, rx_data_q, rx_data_d;
  logic            err_q, err_d, prio_q, prio_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            aw_ok, w_ok, rx_ok, tx_ok, go_poll;
  logic            unused_rdata;

  assign aw_ok = aw_done_q | (awvalid_q & m01_axi_awready);
  assign w_ok  = w_done_q | (wvalid_q & m01_axi_wready);
  assign rx_ok = m01_axi_rdata[0] & ~rx_v_q;
  assign tx_ok = ~m01_axi_rdata[3] & ~tx_ready_q;
  assign unused_rdata = ^m01_axi_rdata[DW-1:8];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= INIT_W;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      tx_ready_q <= 1'b1;
      tx_byte_q  <= '0;
      rx_v_q     <= 1'b0;
      rx_data_q  <= '0;
      err_q      <= 1'b0;
      prio_q     <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      arvalid_q  <= arvalid_d;
      awaddr_q   <= awaddr_d;
      araddr_q   <= araddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      tx_ready_q <= tx_ready_d;
      tx_byte_q  <= tx_byte_d;
      rx_v_q     <= rx_v_d;
      rx_data_q  <= rx_data_d;
      err_q      <= err_d;
      prio_q     <= prio_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    arvalid_d  = arvalid_q;
    awaddr_d   = awaddr_q;
    araddr_d   = araddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    tx_ready_d = tx_ready_q & ~tx_v_i;
    tx_byte_d  = (tx_v_i & tx_ready_q) ? tx_data_i : tx_byte_q;
    rx_v_d     = rx_v_q & ~rx_ready_i;
    rx_data_d  = rx_data_q;
    err_d      = err_q;
    prio_d     = prio_q;
    cnt_d      = cnt_q;
    go_poll    = 1'b0;
    case (state_q)
      INIT_W, TX_W: begin
        // INIT_W enters from reset with valids low, so it raises them itself
        if (state_q == INIT_W) begin
          awaddr_d = A_CTRL;
          wdata_d  = DW'(3);
          wstrb_d  = '1;
        end
        awvalid_d = ~aw_ok;
        wvalid_d  = ~w_ok;
        aw_done_d = aw_ok & ~w_ok;
        w_done_d  = w_ok & ~aw_ok;
        if (aw_ok & w_ok) state_d = (state_q == INIT_W) ? INIT_B : TX_B;
      end
      INIT_B, TX_B: if (m01_axi_bvalid) begin
        err_d   = err_q | (m01_axi_bresp != 2'b00);
        go_poll = 1'b1;
        if (state_q == TX_B) begin
          tx_ready_d = 1'b1;
          prio_d     = ~prio_q;
        end
      end
      POLL_AR, RX_AR: if (arvalid_q & m01_axi_arready) begin
        arvalid_d = 1'b0;
        state_d   = (state_q == POLL_AR) ? POLL_R : RX_R;
      end
      POLL_R: if (m01_axi_rvalid) begin
        err_d = err_q | (m01_axi_rresp != 2'b00) | (|m01_axi_rdata[7:5]);
        if ((m01_axi_rresp != 2'b00) | ~(rx_ok | tx_ok)) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else if (rx_ok & (~tx_ok | ~prio_q)) begin
          state_d   = RX_AR;
          arvalid_d = 1'b1;
          araddr_d  = A_RX;
        end else begin
          state_d   = TX_W;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = A_TX;
          wdata_d   = DW'(tx_byte_q);
          wstrb_d   = SW'(1);
        end
      end
      RX_R: if (m01_axi_rvalid) begin
        go_poll = 1'b1;
        prio_d  = ~prio_q;
        if (m01_axi_rresp == 2'b00) begin
          rx_v_d    = 1'b1;
          rx_data_d = m01_axi_rdata[7:0];
        end else begin
          err_d = 1'b1;
        end
      end
      GAP: begin
        go_poll = cnt_q == '0;
        cnt_d   = (cnt_q == '0) ? cnt_q : cnt_q - 16'd1;
      end
      default: state_d = INIT_W;
    endcase
    if (go_poll) begin
      state_d   = POLL_AR;
      arvalid_d = 1'b1;
      araddr_d  = A_STAT;
    end
  end

  assign tx_ready_o      = tx_ready_q;
  assign rx_data_o       = rx_data_q;
  assign rx_v_o          = rx_v_q;
  assign err_o           = err_q;
  assign m01_axi_awaddr  = awaddr_q;
  assign m01_axi_awprot  = 3'b000;
  assign m01_axi_awvalid = awvalid_q;
  assign m01_axi_wdata   = wdata_q;
  assign m01_axi_wstrb   = wstrb_q;
  assign m01_axi_wvalid  = wvalid_q;
  assign m01_axi_bready  = (state_q == INIT_B) | (state_q == TX_B);
  assign m01_axi_araddr  = araddr_q;
  assign m01_axi_arprot  = 3'b000;
  assign m01_axi_arvalid = arvalid_q;
  assign m01_axi_rready  = (state_q == POLL_R) | (state_q == RX_R);
endmodule

// File: tb/tb_uart_lite_axil_master.sv
// tb_uart_lite_axil_master: directed bench with a reactive AXI-Lite UART-Lite slave model.
module tb_uart_lite_axil_master;
  localparam logic [27:0] A_RX   = 28'h1100000;
  localparam logic [27:0] A_TX   = 28'h1100004;
  localparam logic [27:0] A_STAT = 28'h1100008;
  localparam logic [27:0] A_CTRL = 28'h110000C;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic [7:0]  tx_data_i = '0;
  logic        tx_v_i = 1'b0;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_v_o;
  logic        rx_ready_i = 1'b0;
  logic        err_o;
  logic [27:0] m01_axi_awaddr, m01_axi_araddr;
  logic [2:0]  m01_axi_awprot, m01_axi_arprot;
  logic        m01_axi_awvalid, m01_axi_wvalid, m01_axi_arvalid, m01_axi_bready, m01_axi_rready;
  logic        m01_axi_awready = 1'b1, m01_axi_wready = 1'b1, m01_axi_arready = 1'b1;
  logic [31:0] m01_axi_wdata, m01_axi_rdata;
  logic [3:0]  m01_axi_wstrb;
  logic [1:0]  m01_axi_bresp, m01_axi_rresp;
  logic        m01_axi_bvalid, m01_axi_rvalid;

  always #5 aclk = ~aclk;

  uart_lite_axil_master #(.POLL_GAP(4)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .tx_data_i(tx_data_i), .tx_v_i(tx_v_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_v_o(rx_v_o), .rx_ready_i(rx_ready_i), .err_o(err_o),
    .m01_axi_awaddr(m01_axi_awaddr), .m01_axi_awprot(m01_axi_awprot),
    .m01_axi_awvalid(m01_axi_awvalid), .m01_axi_awready(m01_axi_awready),
    .m01_axi_wdata(m01_axi_wdata), .m01_axi_wstrb(m01_axi_wstrb),
    .m01_axi_wvalid(m01_axi_wvalid), .m01_axi_wready(m01_axi_wready),
    .m01_axi_bresp(m01_axi_bresp), .m01_axi_bvalid(m01_axi_bvalid), .m01_axi_bready(m01_axi_bready),
    .m01_axi_araddr(m01_axi_araddr), .m01_axi_arprot(m01_axi_arprot),
    .m01_axi_arvalid(m01_axi_arvalid), .m01_axi_arready(m01_axi_arready),
    .m01_axi_rdata(m01_axi_rdata), .m01_axi_rresp(m01_axi_rresp),
    .m01_axi_rvalid(m01_axi_rvalid), .m01_axi_rready(m01_axi_rready)
  );

  typedef struct {
    logic        wr;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ev_t;

  ev_t         evs[$];
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  stat = '0;
  logic [7:0]  rx_byte = '0;
  logic [1:0]  rresp_rx = '0;
  int          full_polls = 0;
  logic        aw_got, w_got, aw_ok, w_ok;
  logic [27:0] aw_a;
  logic [31:0] w_d, rd;
  logic [3:0]  w_s;
  ev_t         ev;

  // Zero-wait slave unless the stimulus pulls a ready low; logs every transaction.
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m01_axi_rvalid <= 1'b0;
      m01_axi_rdata  <= '0;
      m01_axi_rresp  <= '0;
      m01_axi_bvalid <= 1'b0;
      m01_axi_bresp  <= '0;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
    end else begin
      if (m01_axi_arvalid && m01_axi_arready) begin
        rd = (m01_axi_araddr == A_STAT) ? {24'h0, stat | ((full_polls > 0) ? 8'h08 : 8'h00)} : {24'h0, rx_byte};
        if (m01_axi_araddr == A_STAT && full_polls > 0 && !tx_ready_o) full_polls = full_polls - 1;
        m01_axi_rvalid <= 1'b1;
        m01_axi_rdata  <= rd;
        m01_axi_rresp  <= (m01_axi_araddr == A_RX) ? rresp_rx : 2'b00;
        ev.wr = 1'b0; ev.addr = m01_axi_araddr; ev.data = rd; ev.strb = 4'h0;
        evs.push_back(ev);
      end else if (m01_axi_rvalid && m01_axi_rready) begin
        m01_axi_rvalid <= 1'b0;
      end
      aw_ok = aw_got || (m01_axi_awvalid && m01_axi_awready);
      w_ok  = w_got || (m01_axi_wvalid && m01_axi_wready);
      if (aw_ok && w_ok) begin
        ev.wr   = 1'b1;
        ev.addr = aw_got ? aw_a : m01_axi_awaddr;
        ev.data = w_got ? w_d : m01_axi_wdata;
        ev.strb = w_got ? w_s : m01_axi_wstrb;
        evs.push_back(ev);
        m01_axi_bvalid <= 1'b1;
        m01_axi_bresp  <= 2'b00;
        aw_got         <= 1'b0;
        w_got          <= 1'b0;
      end else begin
        if (m01_axi_awvalid && m01_axi_awready) begin
          aw_got <= 1'b1;
          aw_a   <= m01_axi_awaddr;
        end
        if (m01_axi_wvalid && m01_axi_wready) begin
          w_got <= 1'b1;
          w_d   <= m01_axi_wdata;
          w_s   <= m01_axi_wstrb;
        end
      end
      if (m01_axi_bvalid && m01_axi_bready) m01_axi_bvalid <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int find_wr(int from);
    for (int i = from; i < evs.size(); i++) if (evs[i].wr && evs[i].addr == A_TX) return i;
    return -1;
  endfunction

  function automatic int count_rd(int from, logic [27:0] a);
    int n = 0;
    for (int i = from; i < evs.size(); i++) if (!evs[i].wr && evs[i].addr == a) n++;
    return n;
  endfunction

  function automatic int count_ops(int from);
    return count_rd(from, A_RX) + ((find_wr(from) >= 0) ? 1 : 0) * 0 + count_wr(from);
  endfunction

  function automatic int count_wr(int from);
    int n = 0;
    for (int i = from; i < evs.size(); i++) if (evs[i].wr && evs[i].addr == A_TX) n++;
    return n;
  endfunction

  initial begin
    int n0, idx, nfull;
    logic [31:0] last_stat;
    int ops[$];
    #2 aresetn = 1'b0;
    #1;
    check("rst_valids", {27'h0, m01_axi_awvalid, m01_axi_wvalid, m01_axi_arvalid, m01_axi_bready, m01_axi_rready}, 32'h0);
    check("rst_awaddr", {4'h0, m01_axi_awaddr}, 32'h0);
    check("rst_araddr", {4'h0, m01_axi_araddr}, 32'h0);
    check("rst_wdata_strb", m01_axi_wdata | {28'h0, m01_axi_wstrb}, 32'h0);
    check("rst_tx_ready", {31'h0, tx_ready_o}, 32'h1);
    check("rst_rx_v_err", {30'h0, rx_v_o, err_o}, 32'h0);
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 100 && evs.size() < 2; i++) @(negedge aclk);
    check("init_seen", {31'h0, evs.size() >= 2}, 32'h1);
    check("init_wr", {31'h0, evs[0].wr}, 32'h1);
    check("init_addr", {4'h0, evs[0].addr}, {4'h0, A_CTRL});
    check("init_data", evs[0].data, 32'h3);
    check("init_strb", {28'h0, evs[0].strb}, 32'hF);
    check("poll_addr", {3'h0, evs[1].wr, evs[1].addr}, {4'h0, A_STAT});

    // RX byte held while the consumer stalls
    stat = 8'h01; rx_byte = 8'h41; rx_ready_i = 1'b0;
    for (int i = 0; i < 200 && !rx_v_o; i++) @(negedge aclk);
    check("rx_valid", {31'h0, rx_v_o}, 32'h1);
    check("rx_data", {24'h0, rx_data_o}, 32'h41);
    n0 = evs.size();
    repeat (40) @(negedge aclk);
    check("rx_no_read_full", count_rd(n0, A_RX), 0);
    check("rx_polls_continue", {31'h0, count_rd(n0, A_STAT) > 0}, 32'h1);
    check("rx_held", {23'h0, rx_v_o, rx_data_o}, 32'h141);
    stat = 8'h00;
    repeat (20) @(negedge aclk);
    rx_ready_i = 1'b1;
    @(negedge aclk);
    rx_ready_i = 1'b0;
    check("rx_consumed", {31'h0, rx_v_o}, 32'h0);

    // TX byte blocked by a full TX FIFO for three polls
    full_polls = 3;
    tx_data_i = 8'h5A; tx_v_i = 1'b1; n0 = evs.size();
    @(negedge aclk);
    tx_v_i = 1'b0;
    check("tx_ready_drop", {31'h0, tx_ready_o}, 32'h0);
    for (int i = 0; i < 400 && find_wr(n0) < 0; i++) @(negedge aclk);
    idx = find_wr(n0);
    nfull = 0;
    last_stat = 32'hFFFF_FFFF;
    for (int i = n0; i < idx; i++) if (!evs[i].wr && evs[i].addr == A_STAT) begin
      if (evs[i].data[3]) nfull++;
      last_stat = evs[i].data;
    end
    check("tx_write_seen", {31'h0, idx >= 0}, 32'h1);
    check("tx_waited_full", {31'h0, nfull >= 3}, 32'h1);
    check("tx_stat_clear", last_stat, 32'h0);
    check("tx_wdata", evs[idx].data, 32'h5A);
    check("tx_wstrb", {28'h0, evs[idx].strb}, 32'h1);
    for (int i = 0; i < 50 && !tx_ready_o; i++) @(negedge aclk);
    check("tx_ready_back", {31'h0, tx_ready_o}, 32'h1);

    // Both directions pending: service must alternate
    stat = 8'h01; rx_ready_i = 1'b1; tx_data_i = 8'hC3; tx_v_i = 1'b1; n0 = evs.size();
    for (int i = 0; i < 600 && count_ops(n0) < 6; i++) @(negedge aclk);
    for (int i = n0; i < evs.size(); i++) begin
      if (evs[i].wr && evs[i].addr == A_TX) ops.push_back(1);
      else if (!evs[i].wr && evs[i].addr == A_RX) ops.push_back(0);
    end
    for (int k = 1; k <= 4; k++) check($sformatf("alternate%0d", k), {31'h0, ops[k] != ops[k+1]}, 32'h1);
    check("tx_data_c3", evs[find_wr(n0)].data, 32'hC3);
    tx_v_i = 1'b0; stat = 8'h00;
    for (int i = 0; i < 100 && !tx_ready_o; i++) @(negedge aclk);
    repeat (10) @(negedge aclk);

    // awready held off after wready handshakes
    m01_axi_awready = 1'b0;
    tx_data_i = 8'h77; tx_v_i = 1'b1;
    @(negedge aclk);
    tx_v_i = 1'b0;
    for (int i = 0; i < 100 && !m01_axi_wvalid; i++) @(negedge aclk);
    check("aw_w_raised", {30'h0, m01_axi_awvalid, m01_axi_wvalid}, 32'h3);
    @(negedge aclk);
    check("w_dropped", {29'h0, m01_axi_awvalid, m01_axi_wvalid, m01_axi_bready}, 32'h4);
    repeat (2) @(negedge aclk);
    check("aw_held", {29'h0, m01_axi_awvalid, m01_axi_wvalid, m01_axi_bready}, 32'h4);
    check("aw_addr_stable", {4'h0, m01_axi_awaddr}, {4'h0, A_TX});
    m01_axi_awready = 1'b1;
    @(negedge aclk);
    check("b_entered", {30'h0, m01_axi_awvalid, m01_axi_bready}, 32'h1);
    for (int i = 0; i < 20 && !tx_ready_o; i++) @(negedge aclk);
    check("aw_delay_done", {31'h0, tx_ready_o}, 32'h1);

    // Failed RX read
    check("err_clean", {31'h0, err_o}, 32'h0);
    rresp_rx = 2'b10; rx_ready_i = 1'b0; stat = 8'h01; n0 = evs.size();
    for (int i = 0; i < 200 && count_rd(n0, A_RX) == 0; i++) @(negedge aclk);
    repeat (3) @(negedge aclk);
    check("rresp_err", {31'h0, err_o}, 32'h1);
    check("rresp_no_rx", {31'h0, rx_v_o}, 32'h0);
    stat = 8'h00;
    repeat (20) @(negedge aclk);
    rresp_rx = 2'b00;
    check("err_sticky", {31'h0, err_o}, 32'h1);

    // Reset mid-transaction, then a status error
    for (int i = 0; i < 50 && !m01_axi_arvalid; i++) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("midrst_valids", {29'h0, m01_axi_arvalid, m01_axi_awvalid, m01_axi_rready}, 32'h0);
    check("midrst_err_txr", {30'h0, err_o, tx_ready_o}, 32'h1);
    evs.delete();
    stat = 8'h20;
    @(negedge aclk);
    aresetn = 1'b1;
    for (int i = 0; i < 100 && !err_o; i++) @(negedge aclk);
    check("stat_err", {31'h0, err_o}, 32'h1);
    check("reinit_addr", {3'h0, evs[0].wr, evs[0].addr}, {4'h1, A_CTRL});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
